brick_field: RTL and testbench

Parametrised brick-wall tracker for the breakout game. It holds per-brick hit points for a ROWS×COLS wall and samples the ball cell on each game tick. Hits decrement the struck brick; destroyed bricks award points, and the block flags level-clear. It sits between the ball-motion block, which supplies row, column and tick, and the display/score renderer, which consumes `bricks`, `score` and the event pulses.

---
 rtl/brick_field_if.sv | 37 +++
 rtl/brick_field.sv | 138 +++++++++++++
 tb/tb_brick_field.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/brick_field_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | brick_field_if                                                       |
// | Ball-position inputs and wall/score outputs of the brick tracker.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface brick_field_if #(
  parameter int ROWS    = 7,
  parameter int COLS    = 8,
  parameter int ROW_W   = 4,
  parameter int COL_W   = 4,
  parameter int SCORE_W = 10
);
  localparam int c_LEFT_W = $clog2(ROWS * COLS + 1);

  logic                   tick;
  logic                   reload;
  logic [ROW_W-1:0]       ball_row;
  logic [COL_W-1:0]       ball_col;
  logic [ROWS*COLS-1:0]   bricks;
  logic [SCORE_W-1:0]     score;
  logic                   hit;
  logic                   destroyed;
  logic                   cleared;
  logic [c_LEFT_W-1:0]    bricks_left;

  modport master (
    output tick, reload, ball_row, ball_col,
    input  bricks, score, hit, destroyed, cleared, bricks_left
  );

  modport slave (
    input  tick, reload, ball_row, ball_col,
    output bricks, score, hit, destroyed, cleared, bricks_left
  );
endinterface
`default_nettype wire

// File: rtl/brick_field.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | brick_field                                                          |
// | Breakout wall tracker: per-brick hit points, scoring, level clear.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module brick_field #(
  parameter int ROWS     = 7,
  parameter int COLS     = 8,
  parameter int BRICK_W  = 2,
  parameter int ROW_W    = 4,
  parameter int COL_W    = 4,
  parameter int HP_W     = 2,
  parameter int INIT_HP  = 1,
  parameter int SCORE_W  = 10,
  parameter int HIT_PTS  = 1,
  parameter int KILL_PTS = 1
) (
  input  logic         clock,
  input  logic         reset,
  brick_field_if.slave bus
);
  localparam int c_N      = ROWS * COLS;
  localparam int c_IDX_W  = (c_N > 1) ? $clog2(c_N) : 1;
  localparam int c_LEFT_W = $clog2(c_N + 1);
  localparam int c_SHIFT  = $clog2(BRICK_W);

  localparam logic [HP_W-1:0]     c_INIT = HP_W'(INIT_HP);
  localparam logic [HP_W-1:0]     c_ONE  = HP_W'(1);
  localparam logic [c_LEFT_W-1:0] c_FULL = c_LEFT_W'(c_N);
  localparam logic [c_LEFT_W-1:0] c_LAST = c_LEFT_W'(1);
  localparam logic [SCORE_W:0]    c_MAX  = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [SCORE_W:0]    c_HIT  = (SCORE_W+1)'(HIT_PTS);
  localparam logic [SCORE_W:0]    c_KILL = (SCORE_W+1)'(KILL_PTS);

  localparam logic [0:0] c_RUN   = 1'b0;
  localparam logic [0:0] c_CLEAR = 1'b1;

  logic [HP_W-1:0]     r_hp [c_N];
  logic [c_N-1:0]      r_alive;
  logic [SCORE_W-1:0]  r_score;
  logic [c_LEFT_W-1:0] r_left;
  logic                r_hit;
  logic                r_destroyed;
  logic [0:0]          r_state;
  logic                r_deb_valid;
  logic [c_IDX_W-1:0]  r_deb_idx;

  logic [COL_W-1:0]    w_brick_col;
  logic                w_valid;
  logic [c_IDX_W-1:0]  w_idx;
  logic [HP_W-1:0]     w_hp_cur;
  logic                w_eval;
  logic                w_same;
  logic                w_strike;
  logic                w_kill;
  logic [SCORE_W:0]    w_sum;
  logic [SCORE_W-1:0]  w_score_nxt;

  always_comb begin
    w_brick_col = bus.ball_col >> c_SHIFT;
    w_valid     = (int'(bus.ball_row) < ROWS) && (int'(w_brick_col) < COLS);
    // Forced to 0 off the wall so the hp lookup never leaves the array.
    w_idx       = '0;
    if (w_valid) begin
      w_idx = c_IDX_W'(int'(bus.ball_row) * COLS + int'(w_brick_col));
    end
    w_hp_cur    = r_hp[w_idx];
    w_eval      = bus.tick && !bus.reload && (r_state == c_RUN);
    w_same      = w_valid && r_deb_valid && (r_deb_idx == w_idx);
    w_strike    = w_eval && w_valid && (w_hp_cur != '0) && !w_same;
    w_kill      = w_strike && (w_hp_cur == c_ONE);
    w_sum       = {1'b0, r_score} + (w_kill ? c_KILL : c_HIT);
    w_score_nxt = (w_sum > c_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_N; i++) begin
        r_hp[i] <= c_INIT;
      end
      r_alive <= '1;
      r_left  <= c_FULL;
    end else if (bus.reload) begin
      for (int i = 0; i < c_N; i++) begin
        r_hp[i] <= c_INIT;
      end
      r_alive <= '1;
      r_left  <= c_FULL;
    end else if (w_strike) begin
      r_hp[w_idx] <= w_hp_cur - c_ONE;
      if (w_kill) begin
        r_alive[w_idx] <= 1'b0;
        r_left         <= r_left - c_LAST;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_score     <= '0;
      r_hit       <= 1'b0;
      r_destroyed <= 1'b0;
      r_state     <= c_RUN;
      r_deb_valid <= 1'b0;
      r_deb_idx   <= '0;
    end else begin
      r_hit       <= w_strike;
      r_destroyed <= w_kill;
      if (w_strike) begin
        r_score <= w_score_nxt;
      end
      if (bus.reload) begin
        r_state     <= c_RUN;
        r_deb_valid <= 1'b0;
      end else if (w_eval) begin
        // A ball resting in the struck brick must leave it before scoring again.
        if (w_strike) begin
          r_deb_valid <= 1'b1;
          r_deb_idx   <= w_idx;
        end else if (!w_same) begin
          r_deb_valid <= 1'b0;
        end
        if (w_kill && (r_left == c_LAST)) begin
          r_state <= c_CLEAR;
        end
      end
    end
  end

  assign bus.bricks      = r_alive;
  assign bus.score       = r_score;
  assign bus.hit         = r_hit;
  assign bus.destroyed   = r_destroyed;
  assign bus.cleared     = (r_state == c_CLEAR);
  assign bus.bricks_left = r_left;
endmodule
`default_nettype wire

// File: tb/tb_brick_field.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_brick_field                                                       |
// | Directed scoreboard bench for brick_field on a 7x7 wall, 2 hp.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_brick_field;
  localparam int ROWS     = 7;
  localparam int COLS     = 7;
  localparam int BRICK_W  = 2;
  localparam int INIT_HP  = 2;
  localparam int SCORE_W  = 6;
  localparam int HIT_PTS  = 1;
  localparam int KILL_PTS = 3;
  localparam int N        = ROWS * COLS;
  localparam int SMAX     = (1 << SCORE_W) - 1;

  typedef struct {
    string          tag;
    logic [N-1:0]   bricks;
    int             score;
    bit             hit;
    bit             dest;
    bit             clr;
    int             left;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int       m_hp [N];
  bit [N-1:0] m_alive;
  int       m_score;
  int       m_left;
  bit       m_dv;
  int       m_di;
  bit       m_clr;
  bit       m_hit;
  bit       m_dest;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  brick_field_if #(.ROWS(ROWS), .COLS(COLS), .ROW_W(4), .COL_W(4), .SCORE_W(SCORE_W)) bus ();

  brick_field #(
    .ROWS(ROWS), .COLS(COLS), .BRICK_W(BRICK_W), .ROW_W(4), .COL_W(4), .HP_W(2),
    .INIT_HP(INIT_HP), .SCORE_W(SCORE_W), .HIT_PTS(HIT_PTS), .KILL_PTS(KILL_PTS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic model_full();
    for (int i = 0; i < N; i++) m_hp[i] = INIT_HP;
    m_alive = '1;
    m_left  = N;
    m_dv    = 1'b0;
    m_clr   = 1'b0;
    m_hit   = 1'b0;
    m_dest  = 1'b0;
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag    = tag;
    e.bricks = m_alive;
    e.score  = m_score;
    e.hit    = m_hit;
    e.dest   = m_dest;
    e.clr    = m_clr;
    e.left   = m_left;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input string field, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, got, exp);
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, "bricks", 64'(bus.bricks), 64'(e.bricks));
      chk(e.tag, "score", 64'(bus.score), 64'(e.score));
      chk(e.tag, "hit", 64'(bus.hit), 64'(e.hit));
      chk(e.tag, "destroyed", 64'(bus.destroyed), 64'(e.dest));
      chk(e.tag, "cleared", 64'(bus.cleared), 64'(e.clr));
      chk(e.tag, "bricks_left", 64'(bus.bricks_left), 64'(e.left));
    end
  endtask

  // Drives one clock of stimulus, predicts the result, then checks it after the edge.
  task automatic step(input bit t, input bit rl, input int row, input int col,
                      input string tag);
    bit v;
    bit same;
    int idx;
    bus.tick     = t;
    bus.reload   = rl;
    bus.ball_row = 4'(row);
    bus.ball_col = 4'(col);
    m_hit  = 1'b0;
    m_dest = 1'b0;
    if (rl) begin
      model_full();
    end else if (t && !m_clr) begin
      v    = (row < ROWS) && ((col / BRICK_W) < COLS);
      idx  = row * COLS + col / BRICK_W;
      same = v && m_dv && (m_di == idx);
      if (v && !same && m_hp[idx] != 0) begin
        m_hp[idx]--;
        m_hit = 1'b1;
        if (m_hp[idx] == 0) begin
          m_dest       = 1'b1;
          m_alive[idx] = 1'b0;
          m_left--;
          m_score += KILL_PTS;
          if (m_left == 0) m_clr = 1'b1;
        end else begin
          m_score += HIT_PTS;
        end
        if (m_score > SMAX) m_score = SMAX;
        m_dv = 1'b1;
        m_di = idx;
      end else if (!same) begin
        m_dv = 1'b0;
      end
    end
    push(tag);
    @(posedge clock);
    #1;
    compare();
    bus.tick   = 1'b0;
    bus.reload = 1'b0;
  endtask

  initial begin
    bus.tick     = 1'b0;
    bus.reload   = 1'b0;
    bus.ball_row = '0;
    bus.ball_col = '0;
    m_score = 0;
    model_full();

    push("reset");
    repeat (2) @(posedge clock);
    #1;
    compare();
    reset = 1'b1;

    step(1, 0, 0, 3, "hit_idx1");
    step(1, 0, 0, 2, "same_brick");
    step(0, 0, 0, 2, "idle");
    step(1, 0, 0, 0, "hit_idx0");
    step(1, 0, 0, 3, "kill_idx1");
    for (int k = 0; k < 5; k++) step(1, 0, 1, 4, "parked");
    step(1, 0, 7, 0, "row_oob");
    step(1, 0, 0, 15, "col_oob");
    step(1, 0, 1, 4, "reentry");

    for (int p = 0; p < 2; p++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          step(1, 0, r, c * BRICK_W, "sweep");

    step(1, 0, 0, 0, "clear_tick");
    step(1, 0, 3, 6, "clear_tick2");
    step(1, 1, 3, 0, "reload_tick");
    step(1, 0, 3, 0, "post_reload");

    // Asynchronous reset between edges, with a tick pending on a live brick.
    bus.tick     = 1'b1;
    bus.ball_row = 4'(4);
    bus.ball_col = 4'(2);
    #2;
    reset   = 1'b0;
    m_score = 0;
    model_full();
    push("async_rst");
    #1;
    compare();
    push("rst_held");
    @(posedge clock);
    #1;
    compare();
    bus.tick = 1'b0;
    reset    = 1'b1;
    step(1, 0, 4, 2, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
